// File: rtl/life_pkg.sv
// Shared definitions for the Life generation sequencer: FSM encoding,
// board geometry defaults and a counter-width helper.
package life_pkg;

    localparam int NUM_TILES_DEF  = 4;
    localparam int POS_W_DEF      = 2;
    localparam int RUN_CYCLES_DEF = 1;
    localparam int GEN_W_DEF      = 16;
    localparam int TILE_W         = 16;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_FRAME = 3'd1,
        ST_LOAD       = 3'd2,
        ST_RUN        = 3'd3,
        ST_STORE      = 3'd4,
        ST_DONE       = 3'd5
    } seq_state_e;

    // Width of a counter that must hold 0..n-1 (never narrower than 1 bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gen_sequencer_if.sv
// Request inputs and tile/strobe outputs of the generation sequencer.
// master = request source / observer, slave = the sequencer.
interface gen_sequencer_if import life_pkg::*; #(
    parameter int POS_W = POS_W_DEF,
    parameter int GEN_W = GEN_W_DEF
);

    logic             tick;
    logic             step;
    logic             enb;
    logic             frame;
    logic [POS_W-1:0] tile_pos;
    logic             load_array;
    logic             run;
    logic             write_mem;
    logic             busy;
    logic             done;
    logic [GEN_W-1:0] gen_count;

    modport master (
        output tick, step, enb, frame,
        input  tile_pos, load_array, run, write_mem, busy, done, gen_count
    );

    modport slave (
        input  tick, step, enb, frame,
        output tile_pos, load_array, run, write_mem, busy, done, gen_count
    );

endinterface

// File: rtl/gen_req_latch.sv
// Generation request arbitration: merges tick/step, holds at most one
// pending request while the sequencer is busy, and remembers its source.
module gen_req_latch (
    input  logic clk,
    input  logic reset,
    input  logic tick_i,
    input  logic step_i,
    input  logic enb_i,
    input  logic idle_i,
    output logic start_o
);

    logic req;
    logic pend_live;
    logic pend_q, pend_d;
    logic pend_tick_q, pend_tick_d;

    always_comb begin
        req         = step_i | (tick_i & enb_i);
        // A held tick request evaporates as soon as enb drops; a held step does not.
        pend_live   = pend_q & ~(pend_tick_q & ~enb_i);
        start_o     = idle_i & (req | pend_live);
        pend_d      = pend_live;
        pend_tick_d = pend_tick_q;
        if (idle_i) begin
            pend_d      = 1'b0;
            pend_tick_d = 1'b0;
        end else if (req && !pend_live) begin
            pend_d      = 1'b1;
            pend_tick_d = ~step_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q      <= 1'b0;
            pend_tick_q <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            pend_tick_q <= pend_tick_d;
        end
    end

endmodule

// File: rtl/gen_sequencer.sv
// Walks every board tile once per generation: LOAD -> RUN -> STORE per tile,
// then DONE. Define GEN_SEQUENCER_FRAME_SYNC_EN to hold each generation in
// WAIT_FRAME until a VESA frame strobe.
module gen_sequencer import life_pkg::*; #(
    parameter int NUM_TILES  = NUM_TILES_DEF,
    parameter int POS_W      = POS_W_DEF,
    parameter int RUN_CYCLES = RUN_CYCLES_DEF,
    parameter int GEN_W      = GEN_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    gen_sequencer_if.slave   seq_io
);

    localparam int                RC_W      = cnt_w(RUN_CYCLES);
    localparam logic [POS_W-1:0]  LAST_TILE = POS_W'(NUM_TILES - 1);
    localparam logic [RC_W-1:0]   LAST_RUN  = RC_W'(RUN_CYCLES - 1);

    if (NUM_TILES < 2)             $error("NUM_TILES must be >= 2");
    if ((2 ** POS_W) < NUM_TILES)  $error("POS_W too narrow for NUM_TILES");
    if (RUN_CYCLES < 1)            $error("RUN_CYCLES must be >= 1");

    seq_state_e       state_q;
    logic [POS_W-1:0] k_q;
    logic [RC_W-1:0]  run_cnt_q;
    logic             load_q, run_q, wr_q, busy_q, done_q;
    logic [GEN_W-1:0] gen_q;
    logic             start;

    gen_req_latch u_req (
        .clk     (clk),
        .reset   (reset),
        .tick_i  (seq_io.tick),
        .step_i  (seq_io.step),
        .enb_i   (seq_io.enb),
        .idle_i  (state_q == ST_IDLE),
        .start_o (start)
    );

`ifndef GEN_SEQUENCER_FRAME_SYNC_EN
    logic unused_frame;
    assign unused_frame = seq_io.frame;
`endif

    // Strobes are computed for the state being entered, so every output is a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            run_cnt_q <= '0;
            load_q    <= 1'b0;
            run_q     <= 1'b0;
            wr_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            gen_q     <= '0;
        end else begin
            load_q <= 1'b0;
            run_q  <= 1'b0;
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        k_q    <= '0;
`ifdef GEN_SEQUENCER_FRAME_SYNC_EN
                        state_q <= ST_WAIT_FRAME;
`else
                        state_q <= ST_LOAD;
                        load_q  <= 1'b1;
`endif
                    end
                end
`ifdef GEN_SEQUENCER_FRAME_SYNC_EN
                ST_WAIT_FRAME: begin
                    if (seq_io.frame) begin
                        state_q <= ST_LOAD;
                        load_q  <= 1'b1;
                    end
                end
`endif
                ST_LOAD: begin
                    state_q   <= ST_RUN;
                    run_q     <= 1'b1;
                    run_cnt_q <= '0;
                end
                ST_RUN: begin
                    if (run_cnt_q == LAST_RUN) begin
                        state_q <= ST_STORE;
                        wr_q    <= 1'b1;
                    end else begin
                        run_cnt_q <= run_cnt_q + RC_W'(1);
                        run_q     <= 1'b1;
                    end
                end
                ST_STORE: begin
                    if (k_q == LAST_TILE) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        k_q     <= '0;
                        gen_q   <= gen_q + GEN_W'(1);
                    end else begin
                        state_q <= ST_LOAD;
                        load_q  <= 1'b1;
                        k_q     <= k_q + POS_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    k_q     <= '0;
                end
            endcase
        end
    end

    assign seq_io.tile_pos   = k_q;
    assign seq_io.load_array = load_q;
    assign seq_io.run        = run_q;
    assign seq_io.write_mem  = wr_q;
    assign seq_io.busy       = busy_q;
    assign seq_io.done       = done_q;
    assign seq_io.gen_count  = gen_q;

endmodule
